// File: rtl/entropy_sample_packer_pkg.sv
// Shared constants and FSM state encoding for the entropy sample packer
// and the extractor-side bench that drives alongside it.
package entropy_sample_packer_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_EMIT    = 3'd2,
        ST_FINAL   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/entropy_rep_health.sv
// Repetition-count health test: counts consecutive identical raw samples and
// raises a sticky fail flag once the run length reaches REP_LIMIT.
module entropy_rep_health #(
    parameter int SAMPLE_WIDTH = 20,
    parameter int REP_LIMIT    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    health_fail
);

    localparam int CW = $clog2(REP_LIMIT + 1);

    logic [SAMPLE_WIDTH-1:0] prev_q;
    logic                    have_prev_q;
    logic [CW-1:0]           rep_cnt_q;
    logic [CW-1:0]           rep_cnt_d;
    logic                    fail_q;

    // Saturate at the limit so a long stuck run cannot wrap the counter.
    always_comb begin
        rep_cnt_d = CW'(1);
        if (have_prev_q && (sample == prev_q)) begin
            rep_cnt_d = (rep_cnt_q == CW'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            rep_cnt_q   <= '0;
            fail_q      <= 1'b0;
        end else if (active && sample_valid) begin
            prev_q      <= sample;
            have_prev_q <= 1'b1;
            rep_cnt_q   <= rep_cnt_d;
            if (rep_cnt_d == CW'(REP_LIMIT)) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign health_fail = fail_q;

endmodule

// File: rtl/entropy_sample_packer.sv
// Packs the noisy low-order bits of AC97 samples into 32-bit words for the
// Keccak extractor, honouring buffer_full and closing each run with an empty block.
module entropy_sample_packer
    import entropy_sample_packer_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 20,
    parameter int BITS_PER_SAMPLE = 4,
    parameter int REP_LIMIT       = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             n_words,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_ready,
    input  logic                    buffer_full,
    output logic [31:0]             entropy,
    output logic [1:0]              entropy_bytes,
    output logic                    entropy_ready,
    output logic                    is_last,
    output logic                    done,
    output logic                    health_fail,
    output logic                    overrun
);

    // state   | meaning
    // IDLE    | waiting for start
    // COLLECT | shifting sample bits into the accumulator
    // EMIT    | holding a completed word until the extractor accepts it
    // FINAL   | sending the empty is_last block
    // DONE    | run complete, done held high

    localparam int         B         = BITS_PER_SAMPLE;
    localparam int         ACC_BITS  = WORD_BITS - B;
    localparam logic [5:0] LAST_FILL = 6'(ACC_BITS);

    state_t                state_q, state_d;
    logic [ACC_BITS-1:0]   acc_q;
    logic [5:0]            bit_cnt_q;
    logic [WORD_BITS-1:0]  word_q;
    logic [WORD_BITS-1:0]  word_cnt_q;
    logic [WORD_BITS-1:0]  n_words_q;
    logic                  overrun_q;
    logic [WORD_BITS-1:0]  acc_next;
    logic                  word_complete;
    logic                  last_word;
    logic                  health_active;

    assign acc_next      = {acc_q, sample[B-1:0]};
    assign word_complete = (bit_cnt_q == LAST_FILL);
    assign last_word     = ((word_cnt_q + 32'd1) == n_words_q);
    assign health_active = (state_q == ST_COLLECT) || (state_q == ST_EMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start in any state wins over everything else and suppresses the
    // strobe of the run it is aborting.
    always_comb begin
        state_d       = state_q;
        entropy       = '0;
        entropy_ready = 1'b0;
        is_last       = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (sample_ready && word_complete) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                entropy = word_q;
                if (!buffer_full) begin
                    entropy_ready = 1'b1;
                    state_d       = last_word ? ST_FINAL : ST_COLLECT;
                end
            end
            ST_FINAL: begin
                if (!buffer_full) begin
                    entropy_ready = 1'b1;
                    is_last       = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        if (start) begin
            state_d       = (n_words == '0) ? ST_FINAL : ST_COLLECT;
            entropy_ready = 1'b0;
            is_last       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            n_words_q  <= '0;
            overrun_q  <= 1'b0;
        end else if (start) begin
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            n_words_q  <= n_words;
            overrun_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (sample_ready) begin
                        if (word_complete) begin
                            word_q    <= acc_next;
                            acc_q     <= '0;
                            bit_cnt_q <= '0;
                        end else begin
                            acc_q     <= acc_next[ACC_BITS-1:0];
                            bit_cnt_q <= bit_cnt_q + 6'(B);
                        end
                    end
                end
                ST_EMIT: begin
                    if (sample_ready) overrun_q <= 1'b1;
                    if (!buffer_full) word_cnt_q <= word_cnt_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    entropy_rep_health #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .REP_LIMIT    (REP_LIMIT)
    ) u_health (
        .clock        (clock),
        .reset        (reset),
        .clear        (start),
        .active       (health_active),
        .sample_valid (sample_ready),
        .sample       (sample),
        .health_fail  (health_fail)
    );

    assign entropy_bytes = 2'b00;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_entropy_sample_packer.sv
// Bench for entropy_sample_packer: a queue-based run model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_entropy_sample_packer;

    localparam int SW  = 20;
    localparam int B   = 4;
    localparam int RL  = 32;
    localparam int SPW = 32 / B;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          sample_ready = 1'b0;
    logic          buffer_full = 1'b0;
    logic [31:0]   n_words = '0;
    logic [SW-1:0] sample = '0;
    logic [31:0]   entropy;
    logic [1:0]    entropy_bytes;
    logic          entropy_ready, is_last, done, health_fail, overrun;

    int total = 0;
    int bad   = 0;
    int n_rdy = 0;
    int n_last = 0;
    bit model_on = 1'b0;

    entropy_sample_packer #(
        .SAMPLE_WIDTH    (SW),
        .BITS_PER_SAMPLE (B),
        .REP_LIMIT       (RL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .n_words       (n_words),
        .sample        (sample),
        .sample_ready  (sample_ready),
        .buffer_full   (buffer_full),
        .entropy       (entropy),
        .entropy_bytes (entropy_bytes),
        .entropy_ready (entropy_ready),
        .is_last       (is_last),
        .done          (done),
        .health_fail   (health_fail),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Run model: words waiting for the extractor, nibbles of the word being
    // built, and how many words of the run have been handed over.
    logic [31:0]   m_pend[$];
    int            m_nibs[$];
    int            m_target, m_emitted, m_rep;
    bit            m_collecting, m_closing, m_done, m_fail, m_ovr, m_have_prev;
    logic [SW-1:0] m_prev;

    function automatic void m_new_run(input bit active, input int target);
        m_pend.delete();
        m_nibs.delete();
        m_target     = target;
        m_emitted    = 0;
        m_collecting = active && (target != 0);
        m_closing    = active && (target == 0);
        m_done       = 0;
        m_fail       = 0;
        m_ovr        = 0;
        m_have_prev  = 0;
        m_rep        = 0;
    endfunction

    function automatic void m_health(input logic [SW-1:0] s);
        if (m_have_prev && s == m_prev) m_rep++;
        else m_rep = 1;
        m_prev      = s;
        m_have_prev = 1;
        if (m_rep >= RL) m_fail = 1;
    endfunction

    function automatic logic [31:0] m_build();
        logic [31:0] w = 0;
        foreach (m_nibs[i]) w = w * (1 << B) + 32'(m_nibs[i]);
        return w;
    endfunction

    always @(negedge clock) begin : compare
        logic [31:0] e_ent;
        bit e_rdy, e_last, busy;
        if (model_on) begin
            busy   = (m_pend.size() > 0);
            e_rdy  = !start && !buffer_full && (busy || m_closing);
            e_last = !start && !buffer_full && !busy && m_closing;
            e_ent  = busy ? m_pend[0] : 32'd0;
            chk("entropy_ready", {31'd0, entropy_ready}, {31'd0, e_rdy});
            chk("is_last", {31'd0, is_last}, {31'd0, e_last});
            chk("entropy", entropy, e_ent);
            chk("entropy_bytes", {30'd0, entropy_bytes}, 32'd0);
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("health_fail", {31'd0, health_fail}, {31'd0, m_fail});
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            if (entropy_ready) n_rdy++;
            if (entropy_ready && is_last) n_last++;

            if (reset) begin
                m_new_run(0, 0);
            end else if (start) begin
                m_new_run(1, int'(n_words));
            end else if (busy) begin
                if (sample_ready) begin
                    m_ovr = 1;
                    m_health(sample);
                end
                if (!buffer_full) begin
                    void'(m_pend.pop_front());
                    m_emitted++;
                    if (m_emitted == m_target) begin
                        m_closing    = 1;
                        m_collecting = 0;
                    end
                end
            end else if (m_closing) begin
                if (!buffer_full) begin
                    m_closing = 0;
                    m_done    = 1;
                end
            end else if (m_collecting && sample_ready) begin
                m_health(sample);
                m_nibs.push_back(int'(sample) % (1 << B));
                if (m_nibs.size() == SPW) begin
                    m_pend.push_back(m_build());
                    m_nibs.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One sample strobe followed by one quiet cycle, so a completed word
    // always gets its EMIT cycle before the next sample arrives.
    task automatic feed(input logic [SW-1:0] s);
        tick();
        sample       = s;
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    task automatic do_start(input int n);
        tick();
        n_words = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    function automatic logic [SW-1:0] mk(input int nib);
        return {16'($urandom), 4'(nib)};
    endfunction

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0, l0, k;
        repeat (3) @(posedge clock);
        #1;
        reset    = 1'b0;
        model_on = 1'b1;

        @(negedge clock);
        chk("rst_ready", {31'd0, entropy_ready}, 32'd0);
        chk("rst_entropy", entropy, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_health", {31'd0, health_fail}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // Basic packing
        do_start(1);
        for (int i = 1; i <= 8; i++) feed(mk(i));
        @(negedge clock);
        chk("basic_ready", {31'd0, entropy_ready}, 32'd1);
        chk("basic_word", entropy, 32'h12345678);
        @(negedge clock);
        chk("basic_last", {31'd0, is_last}, 32'd1);
        chk("basic_last_word", entropy, 32'd0);
        @(negedge clock);
        chk("basic_done", {31'd0, done}, 32'd1);

        // Backpressure with a sample dropped during the stall
        do_start(1);
        for (int i = 0; i < 7; i++) feed(mk(10 + i));
        buffer_full = 1'b1;
        feed(mk(1));
        @(negedge clock);
        chk("bp_stall_ready", {31'd0, entropy_ready}, 32'd0);
        chk("bp_stall_word", entropy, 32'hABCDEF01);
        feed(mk(5));
        @(negedge clock);
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        tick();
        tick();
        buffer_full = 1'b0;
        @(negedge clock);
        chk("bp_ready", {31'd0, entropy_ready}, 32'd1);
        chk("bp_word", entropy, 32'hABCDEF01);
        wait_done(4);

        // Zero-length run
        tick();
        r0 = n_rdy;
        do_start(0);
        k = 0;
        @(negedge clock);
        while (!is_last && k < 2) begin
            @(negedge clock);
            k++;
        end
        chk("zero_last", {31'd0, is_last}, 32'd1);
        wait_done(3);
        tick();
        chk("zero_pulses", 32'(n_rdy - r0), 32'd1);

        // Health: 32 identical samples trip the test
        do_start(4);
        for (int i = 1; i <= 32; i++) begin
            feed(20'h00ABC);
            if (i == 31) begin
                @(negedge clock);
                chk("health_31", {31'd0, health_fail}, 32'd0);
            end
            if (i == 32) begin
                @(negedge clock);
                chk("health_32", {31'd0, health_fail}, 32'd1);
            end
        end
        wait_done(5);

        // Health: 31 identical then one different stays clean
        do_start(4);
        for (int i = 1; i <= 31; i++) feed(20'h00ABC);
        feed(20'h00ABD);
        @(negedge clock);
        chk("health_31_1", {31'd0, health_fail}, 32'd0);
        wait_done(5);

        // Restart mid-run, with a sample coinciding with the restart
        do_start(4);
        for (int i = 0; i < 8; i++) feed(mk(15 - i));
        for (int i = 0; i < 3; i++) feed(mk(2));
        tick();
        n_words      = 4;
        start        = 1'b1;
        sample       = mk(9);
        sample_ready = 1'b1;
        tick();
        start        = 1'b0;
        sample_ready = 1'b0;
        r0 = n_rdy;
        l0 = n_last;
        for (int i = 0; i < 32; i++) begin
            feed(mk((i < 8) ? i + 1 : (i % 15) + 1));
            if (i == 7) begin
                @(negedge clock);
                chk("restart_word1", entropy, 32'h12345678);
            end
        end
        wait_done(5);
        tick();
        chk("restart_pulses", 32'(n_rdy - r0), 32'd5);
        chk("restart_last", 32'(n_last - l0), 32'd1);

        // Reset while stalled in EMIT
        do_start(1);
        buffer_full = 1'b1;
        for (int i = 0; i < 8; i++) feed(mk(i));
        feed(mk(3));
        tick();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        buffer_full = 1'b0;
        r0 = n_rdy;
        @(negedge clock);
        chk("rstmid_ready", {31'd0, entropy_ready}, 32'd0);
        chk("rstmid_entropy", entropy, 32'd0);
        chk("rstmid_overrun", {31'd0, overrun}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        repeat (5) tick();
        chk("rstmid_quiet", 32'(n_rdy - r0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
